stack_sequencer: RTL and testbench

Sequencing engine between the MCU control unit and the stack pointer / scratch RAM pair. Accepts PUSH, POP, CALL and RET requests over a valid/ready handshake. For each request it:
- drives the stack pointer's INCR/DECR controls,
- addresses the scratch RAM from the stack pointer's current output,
- returns popped words to the requester.

The stack grows downward from SP = 0x00, so the first push lands at 0xFF.

---
 rtl/stack_pkg.sv | 27 ++
 rtl/stack_depth_guard.sv | 48 ++++
 rtl/stack_sequencer.sv | 123 ++++++++++++
 tb/tb_stack_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack sequencer.
// Op codes, FSM states, default widths.
package stack_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 10;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } stack_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RDWAIT,
    ST_DONE
  } stack_state_t;

  function automatic logic is_push(stack_op_t op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_depth_guard.sv
// Stack depth counter with sticky over/underflow flag.
// Used only when STACK_GUARD_EN is defined.
module stack_depth_guard
  import stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_chk,
  input  logic pop_chk,
  input  logic fault_clr,
  output logic fault_now,
  output logic fault
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  logic [ADDR_W:0] depth_q, depth_d;
  logic            fault_q, fault_d;

  always_comb begin
    fault_now = (push_chk && depth_q == FULL) ||
                (pop_chk && depth_q == '0);
    depth_d   = depth_q;
    if (push_chk && !fault_now) begin
      depth_d = depth_q + ONE;
    end else if (pop_chk && !fault_now) begin
      depth_d = depth_q - ONE;
    end
    // a new fault outranks a coincident clear
    fault_d = fault_now | (fault_q & ~fault_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: rtl/stack_sequencer.sv
// Sequences PUSH/POP/CALL/RET between control unit and SP/scratch RAM.
// Optional depth guard: define STACK_GUARD_EN.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              OP_VALID,
  input  logic [1:0]        OP,
  input  logic [DATA_W-1:0] WDATA,
  output logic              OP_READY,
  input  logic [ADDR_W-1:0] SP_IN,
  output logic              SP_INCR,
  output logic              SP_DECR,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic [DATA_W-1:0] SCR_WDATA,
  output logic              SCR_WE,
  input  logic [DATA_W-1:0] SCR_RDATA,
  output logic              RES_VALID,
  output logic [DATA_W-1:0] RES_DATA,
  output logic              RES_IS_RET,
  output logic              FAULT,
  input  logic              FAULT_CLR
);

  stack_state_t      state_q, state_d;
  stack_op_t         op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              flt_q, flt_d;
  logic              in_wr, in_rd;
  logic              fault_now;

  assign in_wr = (state_q == ST_WRITE);
  assign in_rd = (state_q == ST_READ);

`ifdef STACK_GUARD_EN
  stack_depth_guard #(
    .ADDR_W(ADDR_W)
  ) u_guard (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push_chk (in_wr),
    .pop_chk  (in_rd),
    .fault_clr(FAULT_CLR),
    .fault_now(fault_now),
    .fault    (FAULT)
  );
`else
  logic unused_fault_clr;
  assign unused_fault_clr = FAULT_CLR;
  assign fault_now        = 1'b0;
  assign FAULT            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    flt_d   = flt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (OP_VALID) begin
          op_d    = stack_op_t'(OP);
          wdata_d = WDATA;
          state_d = is_push(stack_op_t'(OP)) ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        flt_d   = fault_now;
        state_d = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        // a faulted pop returns zero instead of stale RAM data
        res_d   = flt_q ? '0 : SCR_RDATA;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      op_q    <= OP_PUSH;
      wdata_q <= '0;
      res_q   <= '0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      flt_q   <= flt_d;
    end
  end

  // SP_IN is consumed combinationally in the access cycle
  always_comb begin
    SCR_ADDR = '0;
    unique case (1'b1)
      in_wr:   SCR_ADDR = SP_IN - ADDR_W'(1);
      in_rd:   SCR_ADDR = SP_IN;
      default: SCR_ADDR = '0;
    endcase
  end

  assign OP_READY   = (state_q == ST_IDLE);
  assign SP_DECR    = in_wr & ~fault_now;
  assign SP_INCR    = in_rd & ~fault_now;
  assign SCR_WE     = in_wr & ~fault_now;
  assign SCR_WDATA  = in_wr ? wdata_q : '0;
  assign RES_VALID  = (state_q == ST_DONE);
  assign RES_IS_RET = RES_VALID && (op_q == OP_RET);
  assign RES_DATA   = res_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer against a queue-based stack model.
// Covers both builds (STACK_GUARD_EN defined or not).
module tb_stack_sequencer;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam int P_PUSH = 0;
  localparam int P_POP  = 1;
  localparam int P_CALL = 2;
  localparam int P_RET  = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       OP_VALID = 1'b0;
  logic [1:0] OP = 2'd0;
  logic [9:0] WDATA = '0;
  logic       OP_READY;
  logic [7:0] SP_IN;
  logic       SP_INCR, SP_DECR;
  logic [7:0] SCR_ADDR;
  logic [9:0] SCR_WDATA;
  logic       SCR_WE;
  logic [9:0] SCR_RDATA = '0;
  logic       RES_VALID;
  logic [9:0] RES_DATA;
  logic       RES_IS_RET;
  logic       FAULT;
  logic       FAULT_CLR = 1'b0;

  stack_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .OP_VALID(OP_VALID), .OP(OP),
    .WDATA(WDATA), .OP_READY(OP_READY), .SP_IN(SP_IN),
    .SP_INCR(SP_INCR), .SP_DECR(SP_DECR), .SCR_ADDR(SCR_ADDR),
    .SCR_WDATA(SCR_WDATA), .SCR_WE(SCR_WE), .SCR_RDATA(SCR_RDATA),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA),
    .RES_IS_RET(RES_IS_RET), .FAULT(FAULT), .FAULT_CLR(FAULT_CLR)
  );

  always #5 CLK = ~CLK;

  // environment: stack pointer register and synchronous scratch RAM
  logic [7:0] sp;
  logic [9:0] mem [256];
  assign SP_IN = sp;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sp <= 8'h00;
    else if (SP_INCR) sp <= sp + 8'd1;
    else if (SP_DECR) sp <= sp - 8'd1;
  end

  always @(posedge CLK) begin
    if (SCR_WE) mem[SCR_ADDR] <= SCR_WDATA;
    SCR_RDATA <= mem[SCR_ADDR];
  end

  // reference model
  logic [9:0] q[$];
  int         sp_exp = 0;
  bit         fault_exp = 1'b0;
  int         n_asrt = 0;
  int         n_fail = 0;
  bit         rv_seen;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic junk_or_idle();
    if ($urandom_range(0, 1) == 1) begin
      OP_VALID = 1'b1;
      OP       = 2'($urandom_range(0, 3));
      WDATA    = 10'($urandom);
    end else begin
      OP_VALID = 1'b0;
    end
  endtask

  task automatic run_op(input int op, input logic [9:0] data);
    bit         push;
    bit         flt;
    logic [9:0] exp_d;
    push = (op == P_PUSH) || (op == P_CALL);
    flt  = GUARD && (push ? (q.size() >= 256) : (q.size() == 0));
    @(negedge CLK);
    chk("ready_before", OP_READY, 1);
    OP_VALID = 1'b1;
    OP       = 2'(op);
    WDATA    = data;
    @(posedge CLK); #1;
    junk_or_idle();
    if (push) begin
      chk("wr_ready", OP_READY, 0);
      chk("wr_addr", SCR_ADDR, (sp_exp - 1) & 8'hFF);
      chk("wr_wdata", SCR_WDATA, data);
      chk("wr_we", SCR_WE, !flt);
      chk("wr_decr", SP_DECR, !flt);
      chk("wr_incr", SP_INCR, 0);
      @(posedge CLK); #1;
      OP_VALID = 1'b0;
      if (flt) fault_exp = 1'b1;
      else begin
        sp_exp = (sp_exp - 1) & 8'hFF;
        q.push_front(data);
      end
      chk("wr_done_ready", OP_READY, 1);
      chk("wr_done_we", SCR_WE, 0);
      chk("wr_fault", FAULT, fault_exp);
      chk("wr_sp", sp, sp_exp);
    end else begin
      chk("rd_ready", OP_READY, 0);
      chk("rd_addr", SCR_ADDR, sp_exp);
      chk("rd_incr", SP_INCR, !flt);
      chk("rd_decr", SP_DECR, 0);
      chk("rd_we", SCR_WE, 0);
      @(posedge CLK); #1;
      if (flt) fault_exp = 1'b1;
      else sp_exp = (sp_exp + 1) & 8'hFF;
      exp_d = flt ? 10'h0 : q.pop_front();
      chk("rw_incr", SP_INCR, 0);
      chk("rw_addr", SCR_ADDR, 0);
      chk("rw_valid", RES_VALID, 0);
      chk("rw_fault", FAULT, fault_exp);
      @(posedge CLK); #1;
      OP_VALID = 1'b0;
      chk("dn_valid", RES_VALID, 1);
      chk("dn_data", RES_DATA, exp_d);
      chk("dn_isret", RES_IS_RET, op == P_RET);
      chk("dn_ready", OP_READY, 0);
      @(posedge CLK); #1;
      chk("post_valid", RES_VALID, 0);
      chk("post_ready", OP_READY, 1);
      chk("post_hold", RES_DATA, exp_d);
      chk("post_sp", sp, sp_exp);
    end
  endtask

  initial begin
    int op;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", OP_READY, 1);
    chk("rst_incr", SP_INCR, 0);
    chk("rst_decr", SP_DECR, 0);
    chk("rst_addr", SCR_ADDR, 0);
    chk("rst_wdata", SCR_WDATA, 0);
    chk("rst_we", SCR_WE, 0);
    chk("rst_valid", RES_VALID, 0);
    chk("rst_data", RES_DATA, 0);
    chk("rst_isret", RES_IS_RET, 0);
    chk("rst_fault", FAULT, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    run_op(P_PUSH, 10'h155);
    run_op(P_POP, 10'h000);
    run_op(P_CALL, 10'h3A0);
    run_op(P_RET, 10'h000);
    chk("call_ret_net_sp", sp, 0);

    if (GUARD) run_op(P_POP, 10'h000);
    @(negedge CLK);
    FAULT_CLR = 1'b1;
    @(posedge CLK); #1;
    FAULT_CLR = 1'b0;
    fault_exp = 1'b0;
    chk("fault_clr", FAULT, 0);

    for (int i = 0; i < 80; i++) begin
      if (q.size() == 0) op = $urandom_range(0, 1) ? P_PUSH : P_CALL;
      else if (q.size() >= 40) op = $urandom_range(0, 1) ? P_POP : P_RET;
      else op = $urandom_range(0, 3);
      run_op(op, 10'($urandom));
    end

    // reset while a pop sits in its access cycle
    run_op(P_PUSH, 10'h2C3);
    @(negedge CLK);
    OP_VALID = 1'b1;
    OP       = 2'(P_POP);
    @(posedge CLK); #1;
    OP_VALID = 1'b0;
    chk("rr_incr_before", SP_INCR, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("rr_incr_drop", SP_INCR, 0);
    chk("rr_addr", SCR_ADDR, 0);
    chk("rr_ready", OP_READY, 1);
    @(negedge CLK);
    RST_N = 1'b1;
    q.delete();
    sp_exp    = 0;
    fault_exp = 1'b0;
    rv_seen   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (RES_VALID) rv_seen = 1'b1;
    end
    chk("rr_no_valid", rv_seen, 0);
    chk("rr_ready_after", OP_READY, 1);
    chk("rr_data", RES_DATA, 0);

    // fill the whole stack, then one more
    for (int i = 0; i < 256; i++) run_op(P_PUSH, 10'($urandom));
    chk("full_sp", sp, 0);
    run_op(P_PUSH, 10'h1E7);
    chk("overflow_fault", FAULT, GUARD);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
